// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
//   Shared defaults and types for the seq_detect_n serial pattern detector.
//   - PAT_W_DEF / CNT_W_DEF / PAT_RST_DEF : default parameter values
//   - ovl_mode_t                          : readable names for the overlap input
package seq_detect_pkg;

  localparam int                   PAT_W_DEF   = 3;
  localparam int                   CNT_W_DEF   = 8;
  localparam logic [PAT_W_DEF-1:0] PAT_RST_DEF = 3'b011;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_mode_t;

endpackage

// File: rtl/seq_detect_cnt.sv
// seq_detect_cnt
//   Match counter for seq_detect_n.
//   Optional feature macro: SEQ_DETECT_SAT_EN
//     defined   : count stops at all-ones and sat flags that value
//     undefined : count wraps to zero and sat is tied low
//   Ports:
//     clk   in   clock (rising edge)
//     rstn  in   asynchronous active-low reset
//     inc   in   add one to count this edge
//     clr   in   synchronous clear; wins over inc
//     count out  CNT_W-bit detection count
//     sat   out  count is at its maximum (saturating build only)
module seq_detect_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
`ifdef SEQ_DETECT_SAT_EN
      if (count != CNT_MAX) count <= count + 1'b1;
`else
      count <= count + 1'b1;
`endif
    end
  end

`ifdef SEQ_DETECT_SAT_EN
  assign sat = (count == CNT_MAX);
`else
  assign sat = 1'b0;
`endif

endmodule

// File: rtl/seq_detect_n.sv
// seq_detect_n
//   Serial pattern detector with a runtime-loadable PAT_W-bit pattern,
//   overlapping / non-overlapping detection, a registered detection pulse
//   and a match counter (see seq_detect_cnt; macro SEQ_DETECT_SAT_EN selects
//   saturating vs wrapping count).
//   Handshake: x is consumed on a rising edge only when x_valid=1 and load=0;
//   there is no backpressure, one bit per cycle.
//   Ports:
//     clk, rstn        clock, asynchronous active-low reset
//     x, x_valid       serial data bit and its qualifier
//     load, pat_in     load new pattern (first-received bit is MSB), flush history
//     overlap          1 = overlapping detection, 0 = non-overlapping
//     clr              synchronous clear of count and sat
//     det              one-cycle registered detection pulse
//     count, sat       detection count and saturation flag
module seq_detect_n
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             x,
  input  logic             x_valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             clr,
  output logic             det,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat;
  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;

  logic              accept;
  logic [PAT_W-1:0]  hist_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic              match;

  // Match is judged on the history as it will be after this bit shifts in,
  // so det can be registered on the same edge that accepts the last bit.
  always_comb begin
    accept   = x_valid & ~load;
    hist_nxt = {hist[PAT_W-2:0], x};
    fill_nxt = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
    match    = accept && (fill_nxt == FILL_FULL) && (hist_nxt == pat);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat  <= PAT_RST;
      hist <= '0;
      fill <= '0;
      det  <= 1'b0;
    end else if (load) begin
      // The bit presented alongside load is dropped on purpose.
      pat  <= pat_in;
      hist <= '0;
      fill <= '0;
      det  <= 1'b0;
    end else if (accept) begin
      hist <= hist_nxt;
      // Non-overlap restarts the fill so the next match needs PAT_W fresh bits.
      if (match) fill <= overlap ? FILL_FULL : '0;
      else       fill <= fill_nxt;
      det  <= match;
    end else begin
      det  <= 1'b0;
    end
  end

  seq_detect_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (match),
    .clr   (clr),
    .count (count),
    .sat   (sat)
  );

endmodule

// File: tb/tb_seq_detect_n.sv
// tb_seq_detect_n
//   Bench for seq_detect_n with PAT_W=3 and CNT_W=2. A reference model keeps
//   the accepted bits since the last flush in a queue and counts matches as
//   an unbounded integer; the expected count is derived from that integer.
module tb_seq_detect_n;
  import seq_detect_pkg::*;

  localparam int PAT_W = 3;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rstn;
  logic             x;
  logic             x_valid;
  logic             load;
  logic [PAT_W-1:0] pat_in;
  logic             overlap;
  logic             clr;
  logic             det;
  logic [CNT_W-1:0] count;
  logic             sat;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic             hq[$];
  logic [PAT_W-1:0] pat_m;
  int               cnt_m;
  logic             exp_det;

  seq_detect_n #(
    .PAT_W   (PAT_W),
    .CNT_W   (CNT_W),
    .PAT_RST (3'b011)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .x       (x),
    .x_valid (x_valid),
    .load    (load),
    .pat_in  (pat_in),
    .overlap (overlap),
    .clr     (clr),
    .det     (det),
    .count   (count),
    .sat     (sat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    hq.delete();
    pat_m   = 3'b011;
    cnt_m   = 0;
    exp_det = 1'b0;
  endtask

  function automatic logic [CNT_W-1:0] exp_count();
`ifdef SEQ_DETECT_SAT_EN
    return CNT_W'((cnt_m > MAXC) ? MAXC : cnt_m);
`else
    return CNT_W'(cnt_m % (MAXC + 1));
`endif
  endfunction

  function automatic logic exp_sat();
`ifdef SEQ_DETECT_SAT_EN
    return (cnt_m >= MAXC);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [PAT_W-1:0] q_value();
    logic [PAT_W-1:0] v = '0;
    foreach (hq[i]) v = {v[PAT_W-2:0], hq[i]};
    return v;
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of inputs, updates the model at the edge, returns at
  // the following falling edge where outputs are sampled.
  task automatic step(input logic bx, input logic bv, input logic bl,
                      input logic [PAT_W-1:0] bp, input ovl_mode_t bo,
                      input logic bc);
    x       = bx;
    x_valid = bv;
    load    = bl;
    pat_in  = bp;
    overlap = (bo == OVL_ON);
    clr     = bc;
    @(posedge clk);
    if (bl) begin
      pat_m   = bp;
      hq.delete();
      exp_det = 1'b0;
    end else if (bv) begin
      hq.push_back(bx);
      if (hq.size() > PAT_W) void'(hq.pop_front());
      exp_det = (hq.size() == PAT_W) && (q_value() == pat_m);
      if (exp_det) begin
        cnt_m++;
        if (bo == OVL_OFF) hq.delete();
      end
    end else begin
      exp_det = 1'b0;
    end
    if (bc) cnt_m = 0;
    @(negedge clk);
  endtask

  task automatic bit_in(input logic bx, input ovl_mode_t bo);
    step(bx, 1'b1, 1'b0, '0, bo, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; x = 0; x_valid = 0; load = 0; pat_in = '0; overlap = 0; clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_checks++; if (det !== 1'b0) begin n_fail++; $display("FAIL reset_det got %b want 0", det); end
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b want 0", sat); end
  endtask

  task automatic test_default_pattern();
    logic s[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int pulses = 0;
    for (int i = 0; i < 6; i++) begin
      bit_in(s[i], OVL_OFF);
      if (det) pulses++;
      n_checks++;
      if (det !== ((i == 2) || (i == 5))) begin
        n_fail++; $display("FAIL default_det bit%0d got %b want %b", i, det, (i == 2) || (i == 5));
      end
    end
    n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL default_pulses got %0d want 2", pulses); end
    n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL default_count got %0d want 2", count); end
  endtask

  task automatic test_overlap();
    int pulses;
    for (int m = 0; m < 2; m++) begin
      ovl_mode_t mode = (m == 0) ? OVL_ON : OVL_OFF;
      step(1'b0, 1'b0, 1'b1, 3'b111, mode, 1'b1);
      pulses = 0;
      for (int i = 0; i < 7; i++) begin
        bit_in(1'b1, mode);
        if (det) pulses++;
        n_checks++;
        if (det !== exp_det) begin n_fail++; $display("FAIL overlap_det m%0d bit%0d got %b want %b", m, i, det, exp_det); end
      end
      n_checks++;
      if (pulses != ((m == 0) ? 5 : 2)) begin
        n_fail++; $display("FAIL overlap_pulses m%0d got %0d want %0d", m, pulses, (m == 0) ? 5 : 2);
      end
      n_checks++;
      if (count !== exp_count()) begin n_fail++; $display("FAIL overlap_count m%0d got %0d want %0d", m, count, exp_count()); end
    end
  endtask

  task automatic test_gaps_and_load();
    int pulses = 0;
    logic s[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic v[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    step(1'b0, 1'b0, 1'b1, 3'b011, OVL_OFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(s[i], v[i], 1'b0, '0, OVL_OFF, 1'b0);
      if (det) pulses++;
      n_checks++;
      if (det !== (i == 4)) begin n_fail++; $display("FAIL gap_det step%0d got %b want %b", i, det, i == 4); end
    end
    step(1'b0, 1'b0, 1'b0, '0, OVL_OFF, 1'b0);
    n_checks++; if (det !== 1'b0) begin n_fail++; $display("FAIL gap_det_drop got %b want 0", det); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL gap_pulses got %0d want 1", pulses); end
    // 0,1 then load with a 1 presented: bit dropped, history flushed
    bit_in(1'b0, OVL_OFF);
    bit_in(1'b1, OVL_OFF);
    step(1'b1, 1'b1, 1'b1, 3'b011, OVL_OFF, 1'b0);
    n_checks++; if (det !== 1'b0) begin n_fail++; $display("FAIL load_det got %b want 0", det); end
    // flushed history: 1,1 must not complete a match
    for (int i = 0; i < 2; i++) begin
      bit_in(1'b1, OVL_OFF);
      n_checks++; if (det !== 1'b0) begin n_fail++; $display("FAIL load_flush_det bit%0d got %b want 0", i, det); end
    end
  endtask

  task automatic test_counter_limit();
    step(1'b0, 1'b0, 1'b1, 3'b111, OVL_OFF, 1'b1);
    for (int i = 0; i < 15; i++) begin
      bit_in(1'b1, OVL_OFF);
      n_checks++; if (det !== exp_det) begin n_fail++; $display("FAIL limit_det bit%0d got %b want %b", i, det, exp_det); end
    end
`ifdef SEQ_DETECT_SAT_EN
    n_checks++; if (count !== 2'd3) begin n_fail++; $display("FAIL limit_count got %0d want 3", count); end
    n_checks++; if (sat !== 1'b1) begin n_fail++; $display("FAIL limit_sat got %b want 1", sat); end
`else
    n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL limit_count got %0d want 1", count); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL limit_sat got %b want 0", sat); end
`endif
    bit_in(1'b1, OVL_OFF);
    bit_in(1'b1, OVL_OFF);
    step(1'b1, 1'b1, 1'b0, '0, OVL_OFF, 1'b1);
    n_checks++; if (det !== 1'b1) begin n_fail++; $display("FAIL clr_match_det got %b want 1", det); end
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL clr_match_count got %0d want 0", count); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL clr_match_sat got %b want 0", sat); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic bl = ($urandom_range(0, 19) == 0);
      logic bc = ($urandom_range(0, 24) == 0);
      logic bv = ($urandom_range(0, 3) != 0);
      logic [PAT_W-1:0] bp = PAT_W'($urandom_range(0, 7));
      ovl_mode_t bo = ($urandom_range(0, 1) == 1) ? OVL_ON : OVL_OFF;
      step(1'($urandom_range(0, 1)), bv, bl, bp, bo, bc);
      n_checks++; if (det !== exp_det) begin n_fail++; $display("FAIL rand_det cyc%0d got %b want %b", i, det, exp_det); end
      n_checks++; if (count !== exp_count()) begin n_fail++; $display("FAIL rand_count cyc%0d got %0d want %0d", i, count, exp_count()); end
      n_checks++; if (sat !== exp_sat()) begin n_fail++; $display("FAIL rand_sat cyc%0d got %b want %b", i, sat, exp_sat()); end
    end
  endtask

  task automatic test_async_reset();
    logic s[3] = '{1'b0, 1'b1, 1'b1};
    step(1'b0, 1'b0, 1'b1, 3'b011, OVL_OFF, 1'b1);
    for (int i = 0; i < 3; i++) bit_in(s[i], OVL_OFF);
    bit_in(1'b0, OVL_OFF);
    bit_in(1'b1, OVL_OFF);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    n_checks++; if (det !== 1'b0) begin n_fail++; $display("FAIL async_det got %b want 0", det); end
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL async_count got %0d want 0", count); end
    n_checks++; if (sat !== 1'b0) begin n_fail++; $display("FAIL async_sat got %b want 0", sat); end
    @(negedge clk);
    rstn = 1'b1;
    bit_in(1'b1, OVL_OFF);
    n_checks++; if (det !== 1'b0) begin n_fail++; $display("FAIL async_partial_det got %b want 0", det); end
    for (int i = 0; i < 3; i++) begin
      bit_in(s[i], OVL_OFF);
      n_checks++;
      if (det !== (i == 2)) begin n_fail++; $display("FAIL async_after_det bit%0d got %b want %b", i, det, i == 2); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_default_pattern();
    test_overlap();
    test_gaps_and_load();
    test_counter_limit();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_n.md
# seq_detect_n

Parametrised serial pattern detector with a programmable pattern, overlap and non-overlap modes, a detection pulse and a match counter. It generalises the fixed three-bit "011" detector-and-counter to any pattern width, with a runtime-loadable pattern and a bounded-width counter. It sits on a one-bit serial input stream with a valid qualifier and feeds status and counter logic downstream.

## Interface
- `PAT_W`, default 3: pattern length in bits, legal range 2..16.
- `CNT_W`, default 8: match-counter width, legal range 1..32.
- `PAT_RST`, default `3'b011` (PAT_W bits): pattern register value after reset.
- `clk`  in  1  rising-edge clock, the only clock.
- `rstn`  in  1  asynchronous active-low reset.
- `x`  in  1  serial data bit.
- `x_valid`  in  1  `x` is consumed on an edge only when this is 1.
- `load`  in  1  latch `pat_in` into the pattern register and flush the history.
- `pat_in`  in  PAT_W  new pattern; the first-received bit is the MSB.
- `overlap`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `clr`  in  1  synchronous clear of `count` and `sat`.
- `det`  out  1  one-cycle detection pulse, registered.
- `count`  out  CNT_W  number of detections.
- `sat`  out  1  counter-at-maximum flag (see Configuration).

## Operation
- Internal state:
  - `pat`: PAT_W bits, the pattern register.
  - `hist`: PAT_W bits, a shift register. On an accepted bit, `hist <= {hist[PAT_W-2:0], x}`.
  - `fill`: a 0..PAT_W counter of valid history bits. It increments on an accepted bit and saturates at PAT_W.
- A bit is accepted when `x_valid=1` and `load=0`.
- Match condition (combinational, evaluated on the accepted bit): the fill count after the shift equals PAT_W, and the history after the shift equals `pat`.
- On a match:
  - `det` is 1 on the next cycle.
  - `count` increments on the same edge that sets `det`.
  - If `overlap=1`, `fill` stays at PAT_W, so a detection can recur on the very next bit.
  - If `overlap=0`, `fill` resets to 0, so the next match needs PAT_W fresh bits.
- Load:
  - `pat <= pat_in`, `hist <= 0`, `fill <= 0`, `det <= 0`.
  - The bit presented in the same cycle is discarded.
  - `count` is unaffected.
- Clear: `count <= 0` and `sat <= 0`. If a match occurs in the same cycle, `det` still pulses, but `clr` wins and `count` ends at 0.
- `overlap` is sampled per accepted bit. Changing it mid-stream takes effect at the next match.
- `x_valid=0` holds all state; `det` drops to 0.

## Timing
- Reset values (asynchronous, on `rstn=0`): `pat=PAT_RST`, `hist=0`, `fill=0`, `det=0`, `count=0`, `sat=0`.
- Reset asserted mid-pattern abandons the partial match. The first match after release needs PAT_W accepted bits.
- Latency: the final pattern bit is accepted at edge N. At edge N, `det` rises and `count` updates. Both are visible in the cycle after edge N.
- `det` is never high for two consecutive cycles unless there are two consecutive matches. That is only possible with `overlap=1` and a periodic pattern (e.g. all-ones).
- There is no backpressure. One bit is processed per cycle at full rate.

## Configuration
- `SEQ_DETECT_SAT_EN` defined:
  - `count` saturates at 2^CNT_W−1.
  - `sat` is 1 whenever `count` equals that maximum.
  - Further matches still pulse `det`.
- `SEQ_DETECT_SAT_EN` undefined:
  - `count` wraps from 2^CNT_W−1 to 0.
  - `sat` is tied to 0.

## Structure
- Package `seq_detect_pkg`:
  - default `PAT_W`, `CNT_W` and `PAT_RST` constants;
  - an enum `ovl_mode_t` (`OVL_OFF`, `OVL_ON`) for bench readability.
- Sub-module `seq_detect_cnt`:
  - the counter with inputs `inc` and `clr`;
  - outputs `count` and `sat`;
  - the only place the `SEQ_DETECT_SAT_EN` behaviour is implemented.
- Top level holds `pat`, `hist`, `fill`, the match logic and the `det` register.

## Test plan
- **Reset and default pattern.** Reset, PAT_W=3, stream 0,1,1,0,1,1 with `overlap=0` → `det` pulses after the 3rd and 6th bits; `count=2`.
- **Overlap versus non-overlap.** `load` `pat_in=3'b111`, stream seven 1s:
  - `overlap=1` → 5 `det` pulses, `count=5`;
  - `overlap=0` → 2 pulses, `count=2`.
- **Gaps and mid-stream load.**
  - `x_valid` gaps inserted inside the pattern 0,_,1,_,1 → one `det` pulse, one cycle after the last valid bit.
  - `load` after 0,1 with the 3rd bit 1 presented in the same cycle → no `det`, `fill=0`.
- **Counter limit and clear.** CNT_W=2, 5 matches:
  - with `SEQ_DETECT_SAT_EN` → `count=3`, `sat=1`;
  - without it → `count=1`, `sat=0`;
  - then `clr` coincident with a match → `det=1`, `count=0`.
- **Asynchronous reset mid-operation.** Assert `rstn=0` between clock edges after 0,1 → all outputs 0 immediately; after release, 1 alone gives no `det`, and 0,1,1 gives `det`.
